// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory load/store unit: RV32I size codes,
// controller states and the byte-lane / load-extend helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    INIT,
    IDLE
  } dmem_state_e;

  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (funct3)
      F3_B:    m = 4'b0001 << off;
      F3_H:    m = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Store data arrives right-aligned; replicate it so any enabled lane sees it.
  function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] d;
    case (funct3)
      F3_B:    d = {4{wdata[7:0]}};
      F3_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] funct3,
                                              input logic [1:0] off);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    case (funct3)
      F3_B:    r = {{24{s[7]}}, s[7:0]};
      F3_H:    r = {{16{s[15]}}, s[15:0]};
      F3_W:    r = word;
      F3_BU:   r = {24'h0, s[7:0]};
      F3_HU:   r = {16'h0, s[15:0]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 RAM with per-byte write enables and a registered read port.
// The array itself is never reset; the controller clears it by sweeping.
module dmem_bank #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic [3:0]        i_we_mask,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] mem [DEPTH];

  // Read sees the pre-write contents on the same edge; the controller never
  // reads and writes in the same cycle, so this only matters for clarity.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      o_rdata <= mem[i_addr];
    end
    for (int b = 0; b < 4; b++) begin
      if (i_we_mask[b]) begin
        mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with RV32I load/store sizing, fault detection,
// one-cycle registered response and a word-per-cycle clear sweep.
//
// state | meaning
// INIT  | sweeping INIT_VAL into mem[counter], one word per cycle; not ready
// IDLE  | accepting requests; i_clear restarts the sweep
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_rsp_err,
  output logic        o_busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        off;
  logic              addr_oor;
  logic              legal;
  logic              misaligned;
  logic              req_err;
  logic              accept;

  logic              bank_en;
  logic [3:0]        bank_mask;
  logic [ADDR_W-1:0] bank_addr;
  logic [31:0]       bank_wdata;
  logic [31:0]       bank_rdata;

  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_load_q;
  logic [2:0]        rsp_f3_q;
  logic [1:0]        rsp_off_q;

  assign word_idx = i_addr[ADDR_W+1:2];
  assign off      = i_addr[1:0];
  assign addr_oor = |i_addr[31:ADDR_W+2];

  always_comb begin
    legal = 1'b0;
    case (i_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !i_we;
      default:          legal = 1'b0;
    endcase
  end

  assign misaligned = ((i_funct3[1:0] == 2'b01) && off[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (off != 2'b00));
  assign req_err    = !legal || misaligned || addr_oor;

  assign o_req_ready = (state_q == IDLE);
  assign o_busy      = (state_q == INIT);
  assign accept      = i_req_valid && o_req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_en    = 1'b0;
    bank_mask  = 4'b0000;
    bank_addr  = word_idx;
    bank_wdata = store_lanes(i_funct3, i_wdata);
    case (state_q)
      INIT: begin
        bank_addr  = cnt_q;
        bank_mask  = 4'b1111;
        bank_wdata = INIT_VAL;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (accept && !req_err) begin
          bank_en   = !i_we;
          bank_mask = i_we ? byte_mask(i_funct3, off) : 4'b0000;
        end
        // A request in the same cycle as a clear is still served above.
        if (i_clear) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_f3_q    <= 3'b000;
      rsp_off_q   <= 2'b00;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && req_err;
      rsp_load_q  <= accept && !i_we && !req_err;
      if (accept) begin
        rsp_f3_q  <= i_funct3;
        rsp_off_q <= off;
      end
    end
  end

  dmem_bank #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .i_clk     (i_clk),
    .i_en      (bank_en),
    .i_we_mask (bank_mask),
    .i_addr    (bank_addr),
    .i_wdata   (bank_wdata),
    .o_rdata   (bank_rdata)
  );

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rdata     = rsp_load_q ? load_extend(bank_rdata, rsp_f3_q, rsp_off_q) : 32'h0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu against a byte-addressed reference model.
module tb_data_mem_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_rsp_valid;
  logic [31:0] o_rdata;
  logic        o_rsp_err;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_b [1024];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  data_mem_lsu dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_clear),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_rsp_valid (o_rsp_valid),
    .o_rdata     (o_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic void model_clear();
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
  endfunction

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int   nbytes;
    logic lgl;
    lgl = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && ((f3 == 3'd4) || (f3 == 3'd5)));
    nbytes = 1 << f3[1:0];
    rd = 32'h0;
    err = !lgl;
    if (lgl) err = ((addr % nbytes) != 0) || (addr >= 32'd1024);
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) mem_b[10'(addr + 32'(i))] = 8'(wdata >> (8 * i));
      end else begin
        for (int i = 0; i < nbytes; i++) rd = rd | (32'(mem_b[10'(addr + 32'(i))]) << (8 * i));
        if (!f3[2] && nbytes < 4 && rd[8*nbytes-1]) rd = rd | (32'hFFFF_FFFF << (8 * nbytes));
      end
    end
  endfunction

  // Presents one request at the current sample point and returns the response
  // observed just after the accepting edge.
  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd,
                           output logic err, output logic vld);
    i_req_valid = 1'b1;
    i_we        = we;
    i_funct3    = f3;
    i_addr      = addr;
    i_wdata     = wdata;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    rd  = o_rdata;
    err = o_rsp_err;
    vld = o_rsp_valid;
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd;
    logic        err, vld, eerr;
    int          n;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_req_ready !== 1'b0 || o_busy !== 1'b1 || o_rsp_valid !== 1'b0 ||
        o_rdata !== 32'h0 || o_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b busy=%b vld=%b rd=%h err=%b exp 0 1 0 0 0",
               o_req_ready, o_busy, o_rsp_valid, o_rdata, o_rsp_err);
    end
    i_rst_n = 1'b1;
    model_clear();
    n = 0;
    for (int k = 0; k < 400; k++) begin
      if (!o_busy) break;
      n++;
      @(posedge i_clk);
      #1;
    end
    checks++;
    if (n !== 256 || o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_sweep busy_cycles got %0d ready=%b exp 256 ready=1", n, o_req_ready);
    end
    drive_req(1'b0, 3'd2, 32'h000, 32'h0, rd, err, vld);
    model(1'b0, 3'd2, 32'h000, 32'h0, erd, eerr);
    checks++;
    if (vld !== 1'b1 || rd !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_lw0 got vld=%b rd=%h err=%b exp 1 00000000 0", vld, rd, err);
    end
    drive_req(1'b0, 3'd2, 32'h3FC, 32'h0, rd, err, vld);
    model(1'b0, 3'd2, 32'h3FC, 32'h0, erd, eerr);
    checks++;
    if (vld !== 1'b1 || rd !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_lw3fc got vld=%b rd=%h err=%b exp 1 00000000 0", vld, rd, err);
    end
  endtask

  task automatic test_store_load();
    vec_t        v[$];
    logic [31:0] rd, erd;
    logic        err, vld, eerr;
    v.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0000_0000, 1'b0});
    v.push_back('{1'b1, 3'd0, 32'h11, 32'h0000_0080, 32'h0000_0000, 1'b0});
    v.push_back('{1'b0, 3'd0, 32'h11, 32'h0,         32'hFFFF_FF80, 1'b0});
    v.push_back('{1'b0, 3'd4, 32'h11, 32'h0,         32'h0000_0080, 1'b0});
    v.push_back('{1'b0, 3'd2, 32'h10, 32'h0,         32'hDEAD_80EF, 1'b0});
    v.push_back('{1'b1, 3'd1, 32'h22, 32'h0000_8001, 32'h0000_0000, 1'b0});
    v.push_back('{1'b0, 3'd1, 32'h22, 32'h0,         32'hFFFF_8001, 1'b0});
    v.push_back('{1'b0, 3'd5, 32'h22, 32'h0,         32'h0000_8001, 1'b0});
    v.push_back('{1'b0, 3'd2, 32'h20, 32'h0,         32'h8001_0000, 1'b0});
    v.push_back('{1'b0, 3'd0, 32'h23, 32'h0,         32'hFFFF_FF80, 1'b0});
    foreach (v[i]) begin
      drive_req(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, err, vld);
      model(v[i].we, v[i].f3, v[i].addr, v[i].wdata, erd, eerr);
      checks++;
      if (vld !== 1'b1 || rd !== v[i].exp_rd || err !== v[i].exp_err) begin
        errors++;
        $display("FAIL store_load[%0d] got vld=%b rd=%h err=%b exp 1 %h %b",
                 i, vld, rd, err, v[i].exp_rd, v[i].exp_err);
      end
    end
  endtask

  task automatic test_errors();
    vec_t        v[$];
    logic [31:0] rd, erd;
    logic        err, vld, eerr;
    v.push_back('{1'b0, 3'd1, 32'h21,  32'h0,         32'h0,         1'b1});
    v.push_back('{1'b1, 3'd2, 32'h12,  32'h12345678,  32'h0,         1'b1});
    v.push_back('{1'b0, 3'd2, 32'h10,  32'h0,         32'hDEAD_80EF, 1'b0});
    v.push_back('{1'b1, 3'd2, 32'h400, 32'h11111111,  32'h0,         1'b1});
    v.push_back('{1'b0, 3'd2, 32'h400, 32'h0,         32'h0,         1'b1});
    v.push_back('{1'b0, 3'd3, 32'h10,  32'h0,         32'h0,         1'b1});
    v.push_back('{1'b1, 3'd4, 32'h10,  32'h000000FF,  32'h0,         1'b1});
    v.push_back('{1'b1, 3'd1, 32'h13,  32'h0000FFFF,  32'h0,         1'b1});
    v.push_back('{1'b0, 3'd2, 32'h10,  32'h0,         32'hDEAD_80EF, 1'b0});
    v.push_back('{1'b0, 3'd2, 32'h3FC, 32'h0,         32'h0,         1'b0});
    foreach (v[i]) begin
      drive_req(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, err, vld);
      model(v[i].we, v[i].f3, v[i].addr, v[i].wdata, erd, eerr);
      checks++;
      if (vld !== 1'b1 || rd !== v[i].exp_rd || err !== v[i].exp_err) begin
        errors++;
        $display("FAIL errors[%0d] got vld=%b rd=%h err=%b exp 1 %h %b",
                 i, vld, rd, err, v[i].exp_rd, v[i].exp_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd;
    logic        err, vld, eerr;
    drive_req(1'b1, 3'd2, 32'h40, 32'hA5A5A5A5, rd, err, vld);
    model(1'b1, 3'd2, 32'h40, 32'hA5A5A5A5, erd, eerr);
    checks++;
    if (vld !== 1'b1 || err !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL b2b_store got vld=%b rd=%h err=%b exp 1 00000000 0", vld, rd, err);
    end
    drive_req(1'b0, 3'd2, 32'h40, 32'h0, rd, err, vld);
    model(1'b0, 3'd2, 32'h40, 32'h0, erd, eerr);
    checks++;
    if (vld !== 1'b1 || err !== 1'b0 || rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL b2b_load got vld=%b rd=%h err=%b exp 1 a5a5a5a5 0", vld, rd, err);
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle rsp_valid got %b exp 0", o_rsp_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wdata;
    logic        err, vld, eerr, we;
    logic [2:0]  f3;
    for (int it = 0; it < 300; it++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      wdata = $urandom;
      drive_req(we, f3, addr, wdata, rd, err, vld);
      model(we, f3, addr, wdata, erd, eerr);
      checks++;
      if (vld !== 1'b1 || rd !== erd || err !== eerr) begin
        errors++;
        $display("FAIL random[%0d] we=%b f3=%0d addr=%h got vld=%b rd=%h err=%b exp 1 %h %b",
                 it, we, f3, addr, vld, rd, err, erd, eerr);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge i_clk);
        #1;
      end
    end
  endtask

  task automatic test_clear();
    logic [31:0] rd, erd;
    logic        err, vld, eerr;
    int          n;
    drive_req(1'b1, 3'd2, 32'h10, 32'hCAFEF00D, rd, err, vld);
    model(1'b1, 3'd2, 32'h10, 32'hCAFEF00D, erd, eerr);
    i_clear = 1'b1;
    drive_req(1'b0, 3'd2, 32'h10, 32'h0, rd, err, vld);
    i_clear = 1'b0;
    model(1'b0, 3'd2, 32'h10, 32'h0, erd, eerr);
    checks++;
    if (vld !== 1'b1 || rd !== 32'hCAFEF00D || err !== 1'b0) begin
      errors++;
      $display("FAIL clear_same_cycle_load got vld=%b rd=%h err=%b exp 1 cafef00d 0", vld, rd, err);
    end
    model_clear();
    n = 0;
    for (int k = 0; k < 400; k++) begin
      if (!o_busy) break;
      n++;
      i_clear = (k == 50);
      @(posedge i_clk);
      #1;
    end
    i_clear = 1'b0;
    checks++;
    if (n !== 256 || o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_sweep busy_cycles got %0d ready=%b exp 256 ready=1", n, o_req_ready);
    end
    drive_req(1'b0, 3'd2, 32'h10, 32'h0, rd, err, vld);
    model(1'b0, 3'd2, 32'h10, 32'h0, erd, eerr);
    checks++;
    if (vld !== 1'b1 || rd !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL clear_lw10 got vld=%b rd=%h err=%b exp 1 00000000 0", vld, rd, err);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd, erd;
    logic        err, vld, eerr;
    int          n;
    drive_req(1'b1, 3'd2, 32'h0, 32'h12345678, rd, err, vld);
    model(1'b1, 3'd2, 32'h0, 32'h12345678, erd, eerr);
    drive_req(1'b0, 3'd2, 32'h0, 32'h0, rd, err, vld);
    model(1'b0, 3'd2, 32'h0, 32'h0, erd, eerr);
    checks++;
    if (vld !== 1'b1 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL pre_reset_load got vld=%b rd=%h exp 1 12345678", vld, rd);
    end
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_rdata !== 32'h0 || o_busy !== 1'b1 || o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_drop got vld=%b rd=%h busy=%b ready=%b exp 0 00000000 1 0",
               o_rsp_valid, o_rdata, o_busy, o_req_ready);
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (100) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b1 || o_req_ready !== 1'b0 || o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_sweep got busy=%b ready=%b vld=%b exp 1 0 0",
               o_busy, o_req_ready, o_rsp_valid);
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_clear();
    n = 0;
    for (int k = 0; k < 400; k++) begin
      if (!o_busy) break;
      n++;
      @(posedge i_clk);
      #1;
    end
    checks++;
    if (n !== 256 || o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_sweep busy_cycles got %0d ready=%b exp 256 ready=1", n, o_req_ready);
    end
    drive_req(1'b0, 3'd2, 32'h0, 32'h0, rd, err, vld);
    model(1'b0, 3'd2, 32'h0, 32'h0, erd, eerr);
    checks++;
    if (vld !== 1'b1 || rd !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL restart_lw0 got vld=%b rd=%h err=%b exp 1 00000000 0", vld, rd, err);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_random();
    test_clear();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
